// File: rtl/keypad_if.sv
// Keypad matrix lines plus the encoded key strobe toward the display logic.
// Latency: none, this only bundles wires.
// Backpressure: none; key_valid is a one-cycle strobe the consumer must latch.
interface keypad_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // Scanner side: samples rows, drives columns and the key strobe.
    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held
    );

    // Keypad/consumer side.
    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, 2-flop row sync, press/release debounce, key encode.
// Latency: key_valid fires DEBOUNCE_CYCLES-1 cycles after the scan point that captured the key.
// Backpressure: none; key_valid is a one-cycle strobe and key_code holds until the next strobe.
module keypad_scanner #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master kp
);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

    state_t            state, state_nxt;
    logic [3:0]        row_meta, sync_row;
    logic [SCAN_W-1:0] scan_cnt, scan_cnt_nxt;
    logic [DEB_W-1:0]  deb_cnt, deb_cnt_nxt;
    logic [DEB_W-1:0]  rel_cnt, rel_cnt_nxt;
    logic [3:0]        cap_row, cap_row_nxt;
    logic [3:0]        col, col_nxt;
    logic [3:0]        key_code, key_code_nxt;
    logic              key_valid, key_valid_nxt;
    logic              row_onehot;

    // Map the one-hot row/column pair to the key legend:
    // row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = * 0 # D (* = E, # = F).
    function automatic logic [3:0] encode(input logic [3:0] r, input logic [3:0] c);
        logic [1:0] ri, ci;
        logic [3:0] code;
        ri = r[3] ? 2'd3 : r[2] ? 2'd2 : r[1] ? 2'd1 : 2'd0;
        ci = c[3] ? 2'd3 : c[2] ? 2'd2 : c[1] ? 2'd1 : 2'd0;
        case ({ri, ci})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Only a single pressed row is a usable key; zero or multiple rows (ghosting) are ignored.
    assign row_onehot = (sync_row != 4'd0) && ((sync_row & (sync_row - 4'd1)) == 4'd0);

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'd0;
            sync_row <= 4'd0;
        end else begin
            row_meta <= kp.row;
            sync_row <= row_meta;
        end
    end

    // State and datapath registers; reset leaves no strobe pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            scan_cnt  <= '0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            cap_row   <= 4'd0;
            col       <= 4'b0001;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            scan_cnt  <= scan_cnt_nxt;
            deb_cnt   <= deb_cnt_nxt;
            rel_cnt   <= rel_cnt_nxt;
            cap_row   <= cap_row_nxt;
            col       <= col_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
        end
    end

    // Next-state logic: scan/capture, debounce the press, then debounce the release.
    always_comb begin
        state_nxt     = state;
        scan_cnt_nxt  = scan_cnt;
        deb_cnt_nxt   = deb_cnt;
        rel_cnt_nxt   = rel_cnt;
        cap_row_nxt   = cap_row;
        col_nxt       = col;
        key_code_nxt  = key_code;
        key_valid_nxt = 1'b0;
        case (state)
            SCAN: begin
                // Rows are only judged at the end of a column slot so the synchronizer has settled.
                if (scan_cnt == SCAN_LAST) begin
                    scan_cnt_nxt = '0;
                    if (row_onehot) begin
                        cap_row_nxt = sync_row;
                        deb_cnt_nxt = DEB_W'(1);
                        state_nxt   = DEBOUNCE;
                    end else begin
                        col_nxt = {col[2:0], col[3]};
                    end
                end else begin
                    scan_cnt_nxt = scan_cnt + SCAN_W'(1);
                end
            end
            DEBOUNCE: begin
                // A mismatch wins over completion, so a glitch on the last cycle aborts.
                if (sync_row != cap_row) begin
                    scan_cnt_nxt = '0;
                    state_nxt    = SCAN;
                end else if (deb_cnt == DEB_LAST) begin
                    key_code_nxt  = encode(cap_row, col);
                    key_valid_nxt = 1'b1;
                    rel_cnt_nxt   = '0;
                    state_nxt     = HOLD;
                end else begin
                    deb_cnt_nxt = deb_cnt + DEB_W'(1);
                end
            end
            HOLD: begin
                // Any activity on the rows restarts the release count; no repeat strobes here.
                if (sync_row != 4'd0) begin
                    rel_cnt_nxt = '0;
                end else if (rel_cnt == DEB_LAST) begin
                    col_nxt      = {col[2:0], col[3]};
                    scan_cnt_nxt = '0;
                    state_nxt    = SCAN;
                end else begin
                    rel_cnt_nxt = rel_cnt + DEB_W'(1);
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    assign kp.col       = col;
    assign kp.key_code  = key_code;
    assign kp.key_valid = key_valid;
    assign kp.key_held  = (state == HOLD);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a strobe scoreboard and a matrix keypad model.
// Latency: n/a.
// Backpressure: n/a.
module tb_keypad_scanner;
    logic clk = 1'b0;
    logic rst = 1'b1;

    keypad_if kp ();

    // Keypad model: a pressed key connects its row to its column; raw mode forces rows directly.
    logic       raw_mode = 1'b0;
    logic [3:0] raw_row  = 4'd0;
    logic [3:0] key_row  = 4'd0;
    logic [3:0] key_col  = 4'd0;
    assign kp.row = raw_mode ? raw_row : (((kp.col & key_col) != 4'd0) ? key_row : 4'd0);

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_strobe_cyc = -1;
    logic prev_vld = 1'b0;
    logic [3:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest expected key and last exactly one cycle.
    always @(negedge clk) begin
        if (kp.key_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: key_code=%h, required no strobe", kp.key_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (kp.key_code !== e) begin
                    n_fail++;
                    $display("FAIL strobe_code: got %h, required %h", kp.key_code, e);
                end
            end
            n_checks++;
            if (prev_vld) begin
                n_fail++;
                $display("FAIL strobe_width: key_valid high for more than one cycle");
            end
            last_strobe_cyc = cyc;
        end
        prev_vld = kp.key_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Wait for col to switch into tgt; returns one unit after the edge that changed it.
    task automatic wait_col(input logic [3:0] tgt, input int budget);
        logic [3:0] prev;
        prev = kp.col;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (kp.col == tgt && prev != tgt) return;
            prev = kp.col;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_col: col=%b never switched to %b", kp.col, tgt);
    endtask

    task automatic wait_held(input logic val, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (kp.key_held == val) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_held: key_held stuck at %b, required %b", kp.key_held, val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int changes;
        logic [3:0] ec;
        logic [3:0] prev;

        // Reset state and free-running rotation, one column step every 4 cycles.
        repeat (3) @(posedge clk);
        #1;
        check("rst_col", kp.col, 4'b0001);
        check("rst_code", kp.key_code, 4'h0);
        check("rst_valid", kp.key_valid, 1'b0);
        check("rst_held", kp.key_held, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            ec = 4'b0001 << ((k / 4) % 4);
            check("rotate_col", kp.col, ec);
        end
        check("rotate_held", kp.key_held, 1'b0);

        // Bounce: a 5-cycle pulse on column 3 freezes the scan briefly, then scanning resumes there.
        wait_col(4'b1000, 40);
        raw_mode = 1'b1;
        raw_row  = 4'b0001;
        repeat (5) @(posedge clk);
        #1;
        raw_row = 4'd0;
        repeat (5) @(posedge clk);
        #1;
        check("bounce_col_frozen", kp.col, 4'b1000);
        check("bounce_code", kp.key_code, 4'h0);
        check("bounce_held", kp.key_held, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("bounce_resume_col", kp.col, 4'b0001);
        raw_mode = 1'b0;

        // Single press of key 5 (row 1, column 1).
        key_row = 4'b0010;
        key_col = 4'b0010;
        exp_q.push_back(4'h5);
        wait_col(4'b0010, 40);
        c0 = cyc;
        wait_held(1'b1, 40);
        repeat (30) @(posedge clk);
        #1;
        check("press_latency", last_strobe_cyc - c0, 11);
        check("press_code", kp.key_code, 4'h5);
        check("press_held", kp.key_held, 1'b1);
        check("press_col_frozen", kp.col, 4'b0010);

        // Release, then press # (row 3, column 2).
        key_row = 4'd0;
        wait_held(1'b0, 40);
        check("release_col", kp.col, 4'b0100);
        key_row = 4'b1000;
        key_col = 4'b0100;
        exp_q.push_back(4'hF);
        wait_held(1'b1, 40);
        check("hash_code", kp.key_code, 4'hF);
        check("hash_col", kp.col, 4'b0100);
        key_row = 4'd0;
        wait_held(1'b0, 40);
        check("hash_release_col", kp.col, 4'b1000);

        // Ghost keys: two rows at once must never be captured.
        raw_mode = 1'b1;
        raw_row  = 4'b0011;
        changes  = 0;
        prev     = kp.col;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (kp.col != prev) changes++;
            prev = kp.col;
        end
        check("ghost_rotations", changes, 10);
        check("ghost_held", kp.key_held, 1'b0);
        raw_row  = 4'd0;
        raw_mode = 1'b0;

        // Reset in the middle of debouncing key 1.
        key_row = 4'b0001;
        key_col = 4'b0001;
        wait_col(4'b0001, 40);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_deb_col", kp.col, 4'b0001);
        check("rst_deb_code", kp.key_code, 4'h0);
        check("rst_deb_valid", kp.key_valid, 1'b0);
        check("rst_deb_held", kp.key_held, 1'b0);
        key_row = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset while holding key D (row 3, column 3).
        key_row = 4'b1000;
        key_col = 4'b1000;
        exp_q.push_back(4'hD);
        wait_held(1'b1, 60);
        check("d_code", kp.key_code, 4'hD);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_hold_held", kp.key_held, 1'b0);
        check("rst_hold_code", kp.key_code, 4'h0);
        check("rst_hold_col", kp.col, 4'b0001);
        check("rst_hold_valid", kp.key_valid, 1'b0);
        key_row = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
